branch_cond_unit: RTL and testbench
===================================

Name: branch_cond_unit

Overview:
- Consumes the flags produced by the datapath ALU on compare operations (Op 4'b0011) and resolves conditional branches against them.
- Holds a 4-bit architectural flag register {N,Z,C,V}. Evaluates a branch condition and computes the next PC.
- Presents the result to the fetch stage through a registered valid/ready output.
- Sits between the EX stage (ALU flags) and the fetch/PC-select logic.

Parameters:
- AW, 32, address width of PC, offset and target.
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flag_we  in  1  ALU executed a compare this cycle; capture flags
- z_in  in  1  ALU Z flag
- n_in  in  1  ALU N flag
- c_in  in  1  ALU C flag (1 means A >= B unsigned)
- v_in  in  1  ALU V flag
- br_valid  in  1  branch request present
- br_ready  out  1  unit accepts request this cycle
- br_cond  in  4  condition code
- br_pc  in  AW  PC of the branch
- br_offset  in  AW  signed byte offset
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer takes result
- res_taken  out  1  branch taken
- res_target  out  AW  next PC
- res_illegal  out  1  undefined condition code
- flush  in  1  pipeline flush
- flags_q  out  4  registered {N,Z,C,V}
- taken_cnt  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (async, rst_n=0):
  - flags_q=0, flags_vld=0, res_valid=0, res_taken=0, res_target=0, res_illegal=0, taken_cnt=0.
  - The FSM enters IDLE.
- Flag capture: on a clk edge with flag_we=1, flags_q <= {n_in,z_in,c_in,v_in} and flags_vld <= 1. Flush does not affect flags.
- Effective flags for evaluation:
  - When flag_we=1 in the same cycle, use the incoming flags (bypass).
  - Otherwise use flags_q.
- Conditions:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 LT: N^V
  - 0011 GE: !(N^V)
  - 0100 LTU: !C
  - 0101 GEU: C
  - 0110 AL: 1
  - 0111 NV: 0
  - 1000-1111: not taken, res_illegal=1
- Target arithmetic, modulo 2^AW, wrap-around with no error:
  - Taken: res_target = br_pc + br_offset.
  - Not taken: res_target = br_pc + 4.
- FSM states IDLE, WAIT_FLAGS, FULL:
  - IDLE: br_ready=1 if flags_vld, flag_we, or br_cond in {0110,0111,illegal}. Otherwise br_ready=0.
    - br_valid with br_ready goes to FULL.
    - br_valid without br_ready goes to WAIT_FLAGS.
  - WAIT_FLAGS: br_ready=0 until flag_we. On flag_we, br_ready=1 that cycle with bypassed flags. Go to FULL if br_valid is still high, else IDLE.
  - FULL: res_valid=1 and outputs stable until res_ready.
    - br_ready = res_ready, so back-to-back acceptance is allowed (one result per cycle).
    - res_ready without a new request goes to IDLE.
- Latency: result is registered and visible one cycle after acceptance.
- taken_cnt increments by 1 on each accepted taken branch and saturates at all-ones.
- Flush:
  - Clears res_valid, suppresses acceptance that cycle (br_ready=0) and returns to IDLE.
  - Flush has priority over res_ready and br_valid.
  - taken_cnt is not incremented for a request presented during flush.
- Inputs br_cond, br_pc and br_offset must be held while br_valid=1 and br_ready=0.
- Reset asserted mid-operation discards any held result immediately (async). The first edge after rst_n rises behaves as IDLE.

Test Plan:
- Reset, then br_valid, cond=0110, pc=0x100, offset=0x20, res_ready=1 -> next cycle res_valid=1, taken=1, target=0x120, taken_cnt=1.
- flag_we with Z=1, then cond=0000, pc=0x200, offset=-8 -> taken=1, target=0x1F8. Repeat with cond=0001 -> taken=0, target=0x204.
- Reset, br_valid cond=0010 without flags -> br_ready=0 for 3 cycles. Then flag_we N=1,V=0 -> accepted that cycle, next cycle taken=1.
- Compare A=5,B=7 (C=0): cond=0100 -> taken. cond=0101 -> not taken, target=pc+4. Then pc=0xFFFFFFFC not taken -> target=0x00000000.
- res_ready=0 for 2 cycles with a second request pending -> result stable, br_ready=0. Then res_ready=1 -> second result appears the next cycle.
- Result held, flush=1 with br_valid=1 -> res_valid=0 next cycle, request not accepted, flags_q unchanged. Separately, cond=1011 -> res_illegal=1, taken=0.

Source files
------------

// File: rtl/branch_cond_unit.sv
// branch_cond_unit
//   Resolves conditional branches against the architectural {N,Z,C,V} flag
//   register written by ALU compares, computes the next PC and hands the
//   result to fetch through a registered valid/ready output.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   flag_we, n/z/c/v_in   ALU compare flags and their capture strobe
//   br_valid/br_ready     branch request handshake
//   br_cond/pc/offset     condition code, branch PC, signed byte offset
//   res_valid/res_ready   result handshake towards fetch
//   res_taken/target      resolved direction and next PC
//   res_illegal           condition code 1000-1111
//   flush                 pipeline flush (drops result, blocks acceptance)
//   flags_q               registered {N,Z,C,V}
//   taken_cnt             saturating count of accepted taken branches
module branch_cond_unit #(
   parameter int AW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flag_we,
   input  logic             z_in,
   input  logic             n_in,
   input  logic             c_in,
   input  logic             v_in,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [3:0]       br_cond,
   input  logic [AW-1:0]    br_pc,
   input  logic [AW-1:0]    br_offset,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_taken,
   output logic [AW-1:0]    res_target,
   output logic             res_illegal,
   input  logic             flush,
   output logic [3:0]       flags_q,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT_FLAGS, FULL} state_t;

   state_t           r_state, w_next;
   logic [3:0]       r_flags;
   logic             r_flags_vld;
   logic             r_taken, r_illegal;
   logic [AW-1:0]    r_target;
   logic [CNT_W-1:0] r_cnt;

   logic [3:0]       w_flags_in, w_flags;
   logic             w_n, w_z, w_c, w_v;
   logic             w_taken, w_illegal;
   logic             w_no_flags, w_can_eval, w_accept;
   logic [AW-1:0]    w_target;

   assign w_flags_in = {n_in, z_in, c_in, v_in};
   // A compare in the same cycle is forwarded so the branch need not wait.
   assign w_flags    = flag_we ? w_flags_in : r_flags;
   assign {w_n, w_z, w_c, w_v} = w_flags;

   always_comb begin
      w_taken   = 1'b0;
      w_illegal = 1'b0;
      case (br_cond)
         4'b0000: w_taken = w_z;
         4'b0001: w_taken = !w_z;
         4'b0010: w_taken = w_n ^ w_v;
         4'b0011: w_taken = !(w_n ^ w_v);
         4'b0100: w_taken = !w_c;
         4'b0101: w_taken = w_c;
         4'b0110: w_taken = 1'b1;
         4'b0111: w_taken = 1'b0;
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_target = w_taken ? (br_pc + br_offset) : (br_pc + AW'(4));

   // AL, NV and illegal codes resolve without looking at the flags.
   assign w_no_flags = (br_cond == 4'b0110) || (br_cond == 4'b0111) || br_cond[3];
   assign w_can_eval = r_flags_vld || flag_we || w_no_flags;

   always_comb begin
      w_next   = r_state;
      br_ready = 1'b0;
      if (flush) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               br_ready = w_can_eval;
               if (br_valid) w_next = w_can_eval ? FULL : WAIT_FLAGS;
            end
            WAIT_FLAGS: begin
               br_ready = flag_we;
               if (!br_valid)    w_next = IDLE;
               else if (flag_we) w_next = FULL;
            end
            FULL: begin
               // Slot frees when fetch takes the result, so a new request
               // can be accepted in the same cycle. A flag-dependent request
               // that still has no flags parks in WAIT_FLAGS instead.
               if (res_ready) begin
                  br_ready = w_can_eval;
                  if (!br_valid)        w_next = IDLE;
                  else if (!w_can_eval) w_next = WAIT_FLAGS;
               end
            end
            default: w_next = IDLE;
         endcase
      end
   end

   assign w_accept = br_valid && br_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_flags     <= '0;
         r_flags_vld <= 1'b0;
         r_taken     <= 1'b0;
         r_illegal   <= 1'b0;
         r_target    <= '0;
         r_cnt       <= '0;
      end else begin
         r_state <= w_next;
         if (flag_we) begin
            r_flags     <= w_flags_in;
            r_flags_vld <= 1'b1;
         end
         if (w_accept) begin
            r_taken   <= w_taken;
            r_illegal <= w_illegal;
            r_target  <= w_target;
            if (w_taken && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign res_valid   = (r_state == FULL);
   assign res_taken   = r_taken;
   assign res_illegal = r_illegal;
   assign res_target  = r_target;
   assign flags_q     = r_flags;
   assign taken_cnt   = r_cnt;

endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;
   localparam int AW    = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             flag_we = 0, z_in = 0, n_in = 0, c_in = 0, v_in = 0;
   logic             br_valid = 0, br_ready, res_ready = 0, flush = 0;
   logic [3:0]       br_cond = '0;
   logic [AW-1:0]    br_pc = '0, br_offset = '0;
   logic             res_valid, res_taken, res_illegal;
   logic [AW-1:0]    res_target;
   logic [3:0]       flags_q;
   logic [CNT_W-1:0] taken_cnt;

   int n_tests = 0, n_fail = 0;
   int m_cnt = 0;                 // model taken count
   logic [3:0]  m_flags = '0;     // model flags register
   logic [31:0] m_a = 0, m_b = 0; // operands behind current flags

   branch_cond_unit #(.AW(AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .z_in(z_in), .n_in(n_in),
      .c_in(c_in), .v_in(v_in), .br_valid(br_valid), .br_ready(br_ready),
      .br_cond(br_cond), .br_pc(br_pc), .br_offset(br_offset),
      .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
      .res_target(res_target), .res_illegal(res_illegal), .flush(flush),
      .flags_q(flags_q), .taken_cnt(taken_cnt));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Flags an ALU would produce for compare a - b.
   function automatic logic [3:0] cmp_flags(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      d = a - b;
      return {d[31], d == 0, a >= b, (a[31] != b[31]) && (d[31] != a[31])};
   endfunction

   // Expected direction stated directly in terms of the compared operands.
   function automatic bit exp_taken(input logic [3:0] cond, input logic [31:0] a, input logic [31:0] b);
      case (cond)
         4'd0: return a == b;
         4'd1: return a != b;
         4'd2: return $signed(a) <  $signed(b);
         4'd3: return $signed(a) >= $signed(b);
         4'd4: return a <  b;
         4'd5: return a >= b;
         4'd6: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sat_inc(input int c);
      return (c < (1 << CNT_W) - 1) ? c + 1 : c;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_flags = '0; m_a = 0; m_b = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; tick(); tick();
      n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
      n_tests++; if (flags_q !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %h want 0", flags_q); end
      n_tests++; if (taken_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", taken_cnt); end
      n_tests++; if ({res_taken, res_illegal, res_target} !== '0) begin n_fail++; $display("FAIL reset_result got %b/%b/%h want 0", res_taken, res_illegal, res_target); end
      rst_n = 1; model_reset();
   endtask

   task automatic test_always();
      res_ready = 1; br_valid = 1; br_cond = 4'b0110; br_pc = 32'h100; br_offset = 32'h20;
      #1;
      n_tests++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL al_ready got %0b want 1", br_ready); end
      tick(); br_valid = 0; m_cnt = sat_inc(m_cnt);
      n_tests++; if ({res_valid, res_taken} !== 2'b11 || res_target !== 32'h120) begin n_fail++; $display("FAIL al_result got v%0b t%0b %h want v1 t1 120", res_valid, res_taken, res_target); end
      n_tests++; if (taken_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL al_cnt got %0d want %0d", taken_cnt, m_cnt); end
      tick();
   endtask

   task automatic test_eq_ne();
      flag_we = 1; {n_in, z_in, c_in, v_in} = 4'b0100; tick(); flag_we = 0; m_flags = 4'b0100;
      n_tests++; if (flags_q !== m_flags) begin n_fail++; $display("FAIL eq_flags got %b want %b", flags_q, m_flags); end
      res_ready = 1; br_valid = 1; br_cond = 4'b0000; br_pc = 32'h200; br_offset = 32'hFFFF_FFF8;
      tick(); m_cnt = sat_inc(m_cnt);
      n_tests++; if (res_taken !== 1'b1 || res_target !== 32'h1F8) begin n_fail++; $display("FAIL eq_result got t%0b %h want t1 1f8", res_taken, res_target); end
      br_cond = 4'b0001;   // back-to-back in FULL with res_ready=1
      tick(); br_valid = 0;
      n_tests++; if ({res_valid, res_taken} !== 2'b10 || res_target !== 32'h204) begin n_fail++; $display("FAIL ne_result got v%0b t%0b %h want v1 t0 204", res_valid, res_taken, res_target); end
      tick();
   endtask

   task automatic test_async_reset();
      res_ready = 0; br_valid = 1; br_cond = 4'b0110; br_pc = 32'h10; br_offset = 32'h10;
      tick(); br_valid = 0;
      n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %0b want 1", res_valid); end
      #2 rst_n = 0; #1;
      n_tests++; if ({res_valid, taken_cnt, flags_q} !== '0) begin n_fail++; $display("FAIL areset_clear got v%0b cnt%0d f%b want 0", res_valid, taken_cnt, flags_q); end
      tick(); rst_n = 1; model_reset();
   endtask

   task automatic test_wait_flags();
      res_ready = 1; br_valid = 1; br_cond = 4'b0010; br_pc = 32'h300; br_offset = 32'h40;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready c%0d got %0b want 0", i, br_ready); end
         tick();
      end
      flag_we = 1; {n_in, z_in, c_in, v_in} = 4'b1000; #1;
      n_tests++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL wait_bypass_ready got %0b want 1", br_ready); end
      tick(); flag_we = 0; br_valid = 0; m_flags = 4'b1000; m_cnt = sat_inc(m_cnt);
      n_tests++; if ({res_valid, res_taken} !== 2'b11 || res_target !== 32'h340) begin n_fail++; $display("FAIL wait_result got v%0b t%0b %h want v1 t1 340", res_valid, res_taken, res_target); end
      n_tests++; if (flags_q !== m_flags || taken_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL wait_state got f%b cnt%0d want f%b cnt%0d", flags_q, taken_cnt, m_flags, m_cnt); end
      tick();
   endtask

   task automatic test_unsigned();
      m_a = 5; m_b = 7; m_flags = cmp_flags(m_a, m_b);
      flag_we = 1; {n_in, z_in, c_in, v_in} = m_flags; tick(); flag_we = 0;
      res_ready = 1; br_valid = 1; br_cond = 4'b0100; br_pc = 32'h400; br_offset = 32'h10;
      tick(); m_cnt = sat_inc(m_cnt);
      n_tests++; if (res_taken !== 1'b1 || res_target !== 32'h410) begin n_fail++; $display("FAIL ltu got t%0b %h want t1 410", res_taken, res_target); end
      br_cond = 4'b0101; tick();
      n_tests++; if (res_taken !== 1'b0 || res_target !== 32'h404) begin n_fail++; $display("FAIL geu got t%0b %h want t0 404", res_taken, res_target); end
      br_pc = 32'hFFFF_FFFC; tick(); br_valid = 0;
      n_tests++; if (res_taken !== 1'b0 || res_target !== 32'h0) begin n_fail++; $display("FAIL pc_wrap got t%0b %h want t0 0", res_taken, res_target); end
      tick();
   endtask

   task automatic test_backpressure();
      res_ready = 0; br_valid = 1; br_cond = 4'b0110; br_pc = 32'h500; br_offset = 32'h8;
      tick(); m_cnt = sat_inc(m_cnt);
      br_cond = 4'b0111; br_pc = 32'h600;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++; if (br_ready !== 1'b0 || res_valid !== 1'b1 || res_target !== 32'h508 || res_taken !== 1'b1) begin n_fail++; $display("FAIL bp_hold c%0d got rdy%0b v%0b t%0b %h want rdy0 v1 t1 508", i, br_ready, res_valid, res_taken, res_target); end
         tick();
      end
      res_ready = 1; #1;
      n_tests++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", br_ready); end
      tick(); br_valid = 0;
      n_tests++; if ({res_valid, res_taken} !== 2'b10 || res_target !== 32'h604) begin n_fail++; $display("FAIL bp_second got v%0b t%0b %h want v1 t0 604", res_valid, res_taken, res_target); end
      tick();
   endtask

   task automatic test_flush();
      res_ready = 0; br_valid = 1; br_cond = 4'b0110; br_pc = 32'h700; br_offset = 32'h4;
      tick(); m_cnt = sat_inc(m_cnt);
      flush = 1; res_ready = 1; br_pc = 32'h800; #1;
      n_tests++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0b want 0", br_ready); end
      tick(); flush = 0; br_valid = 0;
      n_tests++; if (res_valid !== 1'b0 || taken_cnt !== CNT_W'(m_cnt) || flags_q !== m_flags) begin n_fail++; $display("FAIL flush_state got v%0b cnt%0d f%b want v0 cnt%0d f%b", res_valid, taken_cnt, flags_q, m_cnt, m_flags); end
      br_valid = 1; br_cond = 4'b1011; br_pc = 32'h900; br_offset = 32'h40; #1;
      n_tests++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready got %0b want 1", br_ready); end
      tick(); br_valid = 0;
      n_tests++; if ({res_valid, res_illegal, res_taken} !== 3'b110 || res_target !== 32'h904) begin n_fail++; $display("FAIL illegal got v%0b i%0b t%0b %h want v1 i1 t0 904", res_valid, res_illegal, res_taken, res_target); end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] sum;
      bit          tk;
      int          mode;
      res_ready = 1;
      for (int it = 0; it < 150; it++) begin
         mode = $urandom_range(0, 2);
         if (mode != 2) begin
            m_a = $urandom; m_b = (($urandom & 3) == 0) ? m_a : $urandom;
            m_flags = cmp_flags(m_a, m_b);
            {n_in, z_in, c_in, v_in} = m_flags;
            flag_we = 1;
            if (mode == 0) begin tick(); flag_we = 0; end
         end
         br_valid = 1; br_cond = 4'($urandom); br_pc = $urandom; br_offset = $urandom;
         #1;
         n_tests++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready it%0d got %0b want 1", it, br_ready); end
         tk  = exp_taken(br_cond, m_a, m_b);
         sum = tk ? br_pc + br_offset : br_pc + 32'd4;
         if (tk) m_cnt = sat_inc(m_cnt);
         tick(); flag_we = 0; br_valid = 0;
         n_tests++; if (res_valid !== 1'b1 || res_taken !== tk || res_illegal !== (br_cond >= 4'd8) || res_target !== sum || taken_cnt !== CNT_W'(m_cnt))
            begin n_fail++; $display("FAIL rnd it%0d cond%h got v%0b t%0b i%0b %h cnt%0d want t%0b %h cnt%0d", it, br_cond, res_valid, res_taken, res_illegal, res_target, taken_cnt, tk, sum, m_cnt); end
         tick();
      end
      n_tests++; if (taken_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt got %0d want %0d", taken_cnt, m_cnt); end
   endtask

   task automatic test_saturate();
      res_ready = 1; br_valid = 1; br_cond = 4'b0110; br_pc = 32'h40; br_offset = 32'h4;
      for (int i = 0; i < 20; i++) begin tick(); m_cnt = sat_inc(m_cnt); end
      br_valid = 0;
      n_tests++; if (taken_cnt !== CNT_W'(m_cnt) || m_cnt != (1 << CNT_W) - 1) begin n_fail++; $display("FAIL saturate got %0d want %0d", taken_cnt, (1 << CNT_W) - 1); end
      tick();
   endtask

   initial begin
      test_reset();
      test_always();
      test_eq_ne();
      test_async_reset();
      test_wait_flags();
      test_unsigned();
      test_backpressure();
      test_flush();
      test_random();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
